// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel tick from the divided clock, x/y counters and registered sync/visible decode.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        divided_clk,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic       div_q;
  logic       tick;
  logic       x_wrap;
  logic       y_wrap;
  logic       frame_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;

  assign tick       = divided_clk & ~div_q;
  assign x_wrap     = (x == H_LAST);
  assign y_wrap     = (y == V_LAST);
  assign frame_wrap = tick & x_wrap & y_wrap;

  // Outputs are decoded from these next values so they line up with the registered x/y.
  always_comb begin
    x_next = x;
    y_next = y;
    if (tick) begin
      if (x_wrap) begin
        x_next = '0;
        y_next = y_wrap ? '0 : y + 10'd1;
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div_q       <= divided_clk;
      x           <= x_next;
      y           <= y_next;
      hsync       <= (x_next >= HS_FIRST && x_next <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (y_next >= VS_FIRST && y_next <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
      video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Downstream consumer of the pixel-rate clock divider output.
- Runs entirely in the 100 MHz `clk` domain. It edge-detects the divided clock to form a one-cycle pixel tick, and advances horizontal/vertical counters once per tick.
- Produces VGA sync, the visible-area flag and pixel coordinates for the TicTacToe renderer.
- Default parameters give 640x480 at 60 Hz (800x525 total, 25 MHz pixel rate).

## Interface

Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `hsync`/`vsync` (0 = active-low)

Ports:
- `clk` input 1: system clock, 100 MHz; the only clock
- `rst_n` input 1: asynchronous, active-low reset
- `divided_clk` input 1: pixel-rate square wave from the divider; sampled as data on `clk`, never used as a clock
- `hsync` output 1: horizontal sync
- `vsync` output 1: vertical sync
- `video_on` output 1: high while (`x`,`y`) is in the visible area
- `x` output 10: current horizontal pixel count
- `y` output 10: current vertical line count
- `frame_start` output 1: one-`clk` pulse when counters wrap to (0,0)

## Operation

- The divider output is synchronous to `clk` and has no reset, so no synchronizer is used.
- `div_q` holds a one-flop copy of `divided_clk`.
- `tick = divided_clk & ~div_q`, i.e. the rising edge of the divided clock.
- Horizontal counter `x`:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800).
  - On each tick, `x` increments.
  - At H_TOTAL-1, `x` wraps to 0 and `y` advances.
- Vertical counter `y`:
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
  - `y` advances only on ticks where `x` wraps.
  - At V_TOTAL-1, `y` wraps to 0.
- Counters are 10 bits. H_TOTAL and V_TOTAL must be ≤1024; this is checked by elaboration-time assertion.
- `hsync` is asserted (= SYNC_POL) for x in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], which is [656,751] by default.
- `vsync` is asserted for y in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], which is [490,491] by default.
- `video_on` = (x < H_VISIBLE) && (y < V_VISIBLE).
- `hsync`, `vsync`, `video_on` and `frame_start` are registered. They are decoded from the next-state counter values, so they always match the `x`/`y` presented in the same cycle.
- With no ticks, all state holds; this covers `divided_clk` stuck at 0 or 1.

## Timing

- Reset values (async, on `rst_n` low):
  - `div_q`=0, `x`=0, `y`=0
  - `hsync`=`vsync`=~SYNC_POL
  - `video_on`=1, `frame_start`=0
- Latency: `x`/`y` update on the first `clk` edge where `tick`=1. This is one `clk` after `divided_clk` is seen high, relative to its rising transition.
- Pixel duration: exactly one `divided_clk` period (4 `clk` at the divider's 25 MHz setting).
- `frame_start` goes high on the same edge where `x`,`y` become (0,0) and is low on the next edge. Width is exactly 1 `clk`, not 1 pixel.
- Simultaneous x-wrap and y-wrap: both counters clear on the same edge and `frame_start` pulses.
- If `divided_clk`=1 when `rst_n` releases, the first edge counts as a tick (`div_q`=0): `x` goes to 1.
- Reset mid-frame: all outputs return to their reset values immediately, without waiting for `clk`. Counting resumes from (0,0) on the first tick after release.

## Configuration

- Macro: `VGA_TIMING_FRAME_CNT_EN`.
- Defined:
  - Adds output `frame_cnt`, 16 bits, reset 0.
  - Increments on the edge where `frame_start` rises.
  - Wraps from 0xFFFF to 0.
  - Used by the game for blink and animation timing.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan

All scenarios use a stimulus divider toggling every 2 `clk` (tick every 4 `clk`) with default parameters.

- Reset check: hold `rst_n`=0 -> `x`=0, `y`=0, `hsync`=1, `vsync`=1, `video_on`=1, `frame_start`=0. Assert `rst_n`=0 asynchronously mid-clock -> outputs clear before the next `clk` edge.
- Horizontal line: run one line -> `video_on` falls at x=640. `hsync`=0 exactly for x=656..751 (96 ticks, 384 `clk`). `x` wraps 799→0 and `y` goes 0→1 on the same edge.
- Vertical: run to y=490 -> `vsync`=0 for lines 490 and 491 only (1600 ticks). `video_on`=0 for all y≥480.
- Frame wrap: after 420000 ticks, `x`=`y`=0 and `frame_start` is high for exactly 1 `clk`. With `VGA_TIMING_FRAME_CNT_EN`, `frame_cnt` goes 0→1, then 1→2 after a second frame.
- Stalled divider: hold `divided_clk`=1 for 100 `clk` at x=300, y=100 -> all outputs frozen. On resume, x=301 on the first tick.
- Reset mid-operation: pulse `rst_n` low at x=300, y=100 -> immediate clear. After release, the first tick gives x=1, y=0.
